eeg_aram_agen: RTL and testbench
================================

// Module: eeg_aram_agen
// PURPOSE
//  Multi-bank activation RAM with per-bank internal address generators (base/stride/length).
//  Successor to the plain externally-addressed ARAM: the engine supplies only data streams,
//  one configuration word per command, and receives a DONE pulse.
//  Adds bank-masked WRITE/READ/CLEAR modes, strided wrap-around addressing and
//  backpressure-safe read buffering. Sits between the EEG conv/pool engines and the bank SRAMs.
// PARAMETERS
//  NUM_BANK  4   number of independent banks/channels
//  ADD_AW    12  word address width per bank (depth = 2**ADD_AW)
//  DAT_DW    8   data width per bank
//  LEN_AW    12  transfer length field width (words-1)
// PORTS
//  clk           in   1                  clock
//  rst_n         in   1                  reset, asynchronous, active-low
//  IS_IDLE       out  1                  FSM in IDLE
//  DONE          out  1                  one-cycle pulse when a command completes
//  CFG_INFO_VLD  in   1                  command valid
//  CFG_INFO_RDY  out  1                  command ready (= IS_IDLE)
//  CFG_INFO_CMD  in   2                  0 NOP, 1 WRITE, 2 READ, 3 CLEAR
//  CFG_BANK_MSK  in   NUM_BANK           banks taking part in the command
//  CFG_BASE_ADD  in   ADD_AW             first address
//  CFG_STRIDE    in   ADD_AW             address increment per word
//  CFG_LENGTH    in   LEN_AW             words per bank minus 1
//  WR_DAT_VLD    in   NUM_BANK           per-bank write data valid
//  WR_DAT_RDY    out  NUM_BANK           per-bank write data ready
//  WR_DAT_DAT    in   NUM_BANK*DAT_DW    per-bank write data
//  RD_DAT_VLD    out  NUM_BANK           per-bank read data valid
//  RD_DAT_LST    out  NUM_BANK           last word of this bank's transfer
//  RD_DAT_RDY    in   NUM_BANK           per-bank read data ready
//  RD_DAT_DAT    out  NUM_BANK*DAT_DW    per-bank read data
// BEHAVIOUR
//  Reset: FSM=IDLE; IS_IDLE=1, CFG_INFO_RDY=1, DONE=0, WR_DAT_RDY=0, RD_DAT_VLD=0, RD_DAT_LST=0,
//   RD_DAT_DAT=0; counters, config regs, read buffers cleared. SRAM contents not reset.
//  FSM: IDLE -> WRITE|READ|CLEAR on VLD&RDY (config latched same edge); NOP -> DONE_ST.
//   Active state -> DONE_ST when all done bits set; DONE_ST -> IDLE, DONE=1 for that cycle only.
//   Commands are not accepted outside IDLE; an accepted cmd gives exactly one DONE pulse.
//  Done bits: at accept, done[b] = ~CFG_BANK_MSK[b]; mask=0 -> active state lasts 1 cycle then DONE_ST.
//  Addressing per bank: add_k = (BASE + k*STRIDE) mod 2**ADD_AW, k = 0..LENGTH, via accumulator
//   (no multiplier); wraps silently; STRIDE=0 rereads/rewrites one address.
//  WRITE: WR_DAT_RDY[b] = WRITE & ~done[b]; SRAM write on VLD&RDY at add_k, k++; done[b] set
//   on handshake with k==LENGTH. Banks progress independently; data readable next cycle.
//  READ: bank issues SRAM read (1-cycle latency) only if buffered+in-flight < 2 (2-entry output
//   FIFO per bank); full throughput when RD_DAT_RDY held high. Cmd accepted at edge T ->
//   first RD_DAT_VLD at T+2. RD_DAT_LST with word k==LENGTH; done[b] set on its handshake.
//   VLD/DAT/LST held stable while RDY low. Unmasked banks: VLD=0.
//  CLEAR: writes 0 at add_k, one word per cycle per masked bank, no handshake; LENGTH+1 cycles.
//  Simultaneous: DONE pulse cycle has CFG_INFO_RDY=0; new cmd accepted at earliest next cycle.
//  WR_DAT_VLD outside WRITE, or on a done bank, is ignored (RDY=0).
//  Reset mid-operation: immediate return to IDLE, FIFOs flushed, no DONE pulse.
// STRUCTURE
//  Package eeg_aram_pkg: cmd enum (NOP/WRITE/READ/CLEAR), FSM state localparams, cfg struct.
//  Sub-module eeg_aram_bank: one SRAM bank + address accumulator + 2-entry read FIFO,
//   instantiated NUM_BANK times; top holds FSM, config regs, done bits.
// TESTING
//  WRITE msk=4'b1111 base=0 stride=1 len=15, data=bank*16+k -> 16 writes/bank, one DONE pulse.
//  READ same window, RD_DAT_RDY=1 -> data bank*16+k, first VLD 2 cycles after accept, LST on k=15.
//  READ with RD_DAT_RDY random 50% -> no loss/duplication, data stable while RDY low.
//  WRITE base=0xFFE stride=3 len=2 -> addresses 0xFFE,0x001,0x004; READ confirms wrap.
//  CLEAR msk=4'b0101 len=7 -> DONE after 8 cycles; banks 0,2 read 0, banks 1,3 unchanged.
//  msk=0 or NOP -> DONE within 2 cycles; rst_n low mid-READ -> IDLE, VLD=0, no DONE.

Source files
------------

// File: rtl/eeg_aram_pkg.sv
// Shared types and constants for the strided multi-bank activation RAM.
// Holds the command encoding, FSM state codes and the latched per-command configuration.
package eeg_aram_pkg;

   localparam int PKG_NUM_BANK = 4;
   localparam int PKG_ADD_AW   = 12;
   localparam int PKG_DAT_DW   = 8;
   localparam int PKG_LEN_AW   = 12;

   typedef enum logic [1:0] {
      CMD_NOP   = 2'd0,
      CMD_WRITE = 2'd1,
      CMD_READ  = 2'd2,
      CMD_CLEAR = 2'd3
   } cmd_e;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WRITE = 3'd1;
   localparam logic [2:0] ST_READ  = 3'd2;
   localparam logic [2:0] ST_CLEAR = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Base address is consumed directly by the banks at accept, so only stride/length are kept.
   typedef struct packed {
      logic [PKG_ADD_AW-1:0] stride;
      logic [PKG_LEN_AW-1:0] length;
   } cfg_t;

   function automatic logic [2:0] cmd_state(input cmd_e cmd);
      logic [2:0] st;
      case (cmd)
         CMD_WRITE: st = ST_WRITE;
         CMD_READ:  st = ST_READ;
         CMD_CLEAR: st = ST_CLEAR;
         CMD_NOP:   st = ST_DONE;
         default:   st = ST_DONE;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/eeg_aram_bank.sv
// One activation RAM bank: SRAM array, base/stride address accumulator and a
// two-entry registered read buffer (output register plus skid register).
module eeg_aram_bank
   import eeg_aram_pkg::*;
#(
   parameter int ADD_AW = PKG_ADD_AW,
   parameter int DAT_DW = PKG_DAT_DW,
   parameter int LEN_AW = PKG_LEN_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADD_AW-1:0] base,
   input  logic [ADD_AW-1:0] stride,
   input  logic [LEN_AW-1:0] length,
   input  logic              wr_en,
   input  logic              wr_vld,
   input  logic [DAT_DW-1:0] wr_dat,
   input  logic              rd_act,
   input  logic              clr_act,
   input  logic              rd_rdy,
   output logic              rd_vld,
   output logic              rd_lst,
   output logic [DAT_DW-1:0] rd_dat,
   output logic              fin
);

   localparam int DEPTH = 1 << ADD_AW;

   logic [DAT_DW-1:0] mem_r [DEPTH];
   logic [DAT_DW-1:0] mem_q_r;
   logic [ADD_AW-1:0] addr_r;
   logic [LEN_AW-1:0] k_r;
   logic              iss_done_r;
   logic              infl_r;
   logic              infl_lst_r;
   logic              out_v_r;
   logic              out_lst_r;
   logic [DAT_DW-1:0] out_dat_r;
   logic              skid_v_r;
   logic              skid_lst_r;
   logic [DAT_DW-1:0] skid_dat_r;

   logic              wr_hs_s;
   logic              last_k_s;
   logic              pop_s;
   logic              rd_iss_s;
   logic              mem_we_s;
   logic              step_s;
   logic [DAT_DW-1:0] mem_wd_s;
   logic [1:0]        occ_s;

   // Access decode; occupancy counts the word leaving this cycle so RDY=1 streams every cycle.
   always_comb begin
      wr_hs_s  = wr_en & wr_vld;
      last_k_s = (k_r == length);
      pop_s    = out_v_r & rd_rdy;
      occ_s    = {1'b0, out_v_r} + {1'b0, skid_v_r} + {1'b0, infl_r} - {1'b0, pop_s};
      rd_iss_s = rd_act & ~iss_done_r & (occ_s < 2'd2);
      mem_we_s = wr_hs_s | clr_act;
      if (clr_act) begin
         mem_wd_s = {DAT_DW{1'b0}};
      end else begin
         mem_wd_s = wr_dat;
      end
      step_s = mem_we_s | rd_iss_s;
      fin    = (mem_we_s & last_k_s) | (pop_s & out_lst_r);
   end

   // SRAM array with one-cycle registered read port; contents are not reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[addr_r] <= mem_wd_s;
      end
      if (rd_iss_s) begin
         mem_q_r <= mem_r[addr_r];
      end
   end

   // Address accumulator and word counter, plus the in-flight read tag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r     <= {ADD_AW{1'b0}};
         k_r        <= {LEN_AW{1'b0}};
         iss_done_r <= 1'b0;
         infl_r     <= 1'b0;
         infl_lst_r <= 1'b0;
      end else begin
         if (start) begin
            addr_r     <= base;
            k_r        <= {LEN_AW{1'b0}};
            iss_done_r <= 1'b0;
         end else if (step_s) begin
            addr_r <= addr_r + stride;
            k_r    <= k_r + {{(LEN_AW-1){1'b0}}, 1'b1};
            if (rd_iss_s && last_k_s) begin
               iss_done_r <= 1'b1;
            end
         end
         infl_r     <= rd_iss_s;
         infl_lst_r <= rd_iss_s & last_k_s;
      end
   end

   // Output/skid register pair; the skid only fills while the output is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_v_r    <= 1'b0;
         out_lst_r  <= 1'b0;
         out_dat_r  <= {DAT_DW{1'b0}};
         skid_v_r   <= 1'b0;
         skid_lst_r <= 1'b0;
         skid_dat_r <= {DAT_DW{1'b0}};
      end else if (!out_v_r || pop_s) begin
         if (skid_v_r) begin
            out_v_r    <= 1'b1;
            out_lst_r  <= skid_lst_r;
            out_dat_r  <= skid_dat_r;
            skid_v_r   <= infl_r;
            skid_lst_r <= infl_lst_r;
            skid_dat_r <= mem_q_r;
         end else begin
            out_v_r   <= infl_r;
            out_lst_r <= infl_r & infl_lst_r;
            if (infl_r) begin
               out_dat_r <= mem_q_r;
            end
         end
      end else if (infl_r) begin
         skid_v_r   <= 1'b1;
         skid_lst_r <= infl_lst_r;
         skid_dat_r <= mem_q_r;
      end
   end

   assign rd_vld = out_v_r;
   assign rd_lst = out_lst_r;
   assign rd_dat = out_dat_r;

endmodule

// File: rtl/eeg_aram_agen.sv
// Multi-bank activation RAM with per-bank internal address generators.
// Top level: command FSM, latched configuration and per-bank done bits.
module eeg_aram_agen
   import eeg_aram_pkg::*;
#(
   parameter int NUM_BANK = PKG_NUM_BANK,
   parameter int ADD_AW   = PKG_ADD_AW,
   parameter int DAT_DW   = PKG_DAT_DW,
   parameter int LEN_AW   = PKG_LEN_AW
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic                       IS_IDLE,
   output logic                       DONE,
   input  logic                       CFG_INFO_VLD,
   output logic                       CFG_INFO_RDY,
   input  logic [1:0]                 CFG_INFO_CMD,
   input  logic [NUM_BANK-1:0]        CFG_BANK_MSK,
   input  logic [ADD_AW-1:0]          CFG_BASE_ADD,
   input  logic [ADD_AW-1:0]          CFG_STRIDE,
   input  logic [LEN_AW-1:0]          CFG_LENGTH,
   input  logic [NUM_BANK-1:0]        WR_DAT_VLD,
   output logic [NUM_BANK-1:0]        WR_DAT_RDY,
   input  logic [NUM_BANK*DAT_DW-1:0] WR_DAT_DAT,
   output logic [NUM_BANK-1:0]        RD_DAT_VLD,
   output logic [NUM_BANK-1:0]        RD_DAT_LST,
   input  logic [NUM_BANK-1:0]        RD_DAT_RDY,
   output logic [NUM_BANK*DAT_DW-1:0] RD_DAT_DAT
);

   logic [2:0]          state_r;
   logic [2:0]          state_nxt_s;
   cfg_t                cfg_r;
   logic [NUM_BANK-1:0] done_r;
   logic [NUM_BANK-1:0] done_nxt_s;
   logic [NUM_BANK-1:0] wr_rdy_r;
   logic                is_idle_r;
   logic                done_p_r;

   logic                accept_s;
   logic                act_s;
   logic                all_done_s;
   logic [NUM_BANK-1:0] rd_act_s;
   logic [NUM_BANK-1:0] clr_act_s;
   logic [NUM_BANK-1:0] fin_s;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = cmd_state(cmd_e'(CFG_INFO_CMD));
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WRITE, ST_READ, ST_CLEAR: begin
            if (all_done_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM output decode: command acceptance and per-bank activity strobes.
   always_comb begin
      accept_s = CFG_INFO_VLD & is_idle_r;
      act_s    = (state_r == ST_WRITE) | (state_r == ST_READ) | (state_r == ST_CLEAR);
      if (state_r == ST_READ) begin
         rd_act_s = ~done_r;
      end else begin
         rd_act_s = {NUM_BANK{1'b0}};
      end
      if (state_r == ST_CLEAR) begin
         clr_act_s = ~done_r;
      end else begin
         clr_act_s = {NUM_BANK{1'b0}};
      end
   end

   // Done-bit update; including this cycle's finishes lets the FSM leave without an idle cycle.
   always_comb begin
      all_done_s = &(done_r | fin_s);
      if (accept_s) begin
         done_nxt_s = ~CFG_BANK_MSK;
      end else if (act_s) begin
         done_nxt_s = done_r | fin_s;
      end else begin
         done_nxt_s = done_r;
      end
   end

   // Registered status/handshake outputs, done bits and latched configuration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_idle_r <= 1'b1;
         done_p_r  <= 1'b0;
         done_r    <= {NUM_BANK{1'b0}};
         wr_rdy_r  <= {NUM_BANK{1'b0}};
         cfg_r     <= '0;
      end else begin
         is_idle_r <= (state_nxt_s == ST_IDLE);
         done_p_r  <= (state_nxt_s == ST_DONE);
         done_r    <= done_nxt_s;
         if (state_nxt_s == ST_WRITE) begin
            wr_rdy_r <= ~done_nxt_s;
         end else begin
            wr_rdy_r <= {NUM_BANK{1'b0}};
         end
         if (accept_s) begin
            cfg_r.stride <= CFG_STRIDE;
            cfg_r.length <= CFG_LENGTH;
         end
      end
   end

   for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
      eeg_aram_bank #(
         .ADD_AW (ADD_AW),
         .DAT_DW (DAT_DW),
         .LEN_AW (LEN_AW)
      ) u_bank (
         .clk     (clk),
         .rst_n   (rst_n),
         .start   (accept_s),
         .base    (CFG_BASE_ADD),
         .stride  (cfg_r.stride),
         .length  (cfg_r.length),
         .wr_en   (wr_rdy_r[b]),
         .wr_vld  (WR_DAT_VLD[b]),
         .wr_dat  (WR_DAT_DAT[b*DAT_DW +: DAT_DW]),
         .rd_act  (rd_act_s[b]),
         .clr_act (clr_act_s[b]),
         .rd_rdy  (RD_DAT_RDY[b]),
         .rd_vld  (RD_DAT_VLD[b]),
         .rd_lst  (RD_DAT_LST[b]),
         .rd_dat  (RD_DAT_DAT[b*DAT_DW +: DAT_DW]),
         .fin     (fin_s[b])
      );
   end

   assign IS_IDLE      = is_idle_r;
   assign CFG_INFO_RDY = is_idle_r;
   assign DONE         = done_p_r;
   assign WR_DAT_RDY   = wr_rdy_r;

endmodule

// File: tb/tb_eeg_aram_agen.sv
// Self-checking bench for eeg_aram_agen: directed command sequence with random
// data/backpressure, checked against an address-arithmetic memory model.
module tb_eeg_aram_agen;

   localparam int NB = 4;
   localparam int AW = 12;
   localparam int DW = 8;
   localparam int LW = 12;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          IS_IDLE, DONE, CFG_INFO_VLD, CFG_INFO_RDY;
   logic [1:0]    CFG_INFO_CMD;
   logic [NB-1:0] CFG_BANK_MSK;
   logic [AW-1:0] CFG_BASE_ADD, CFG_STRIDE;
   logic [LW-1:0] CFG_LENGTH;
   logic [NB-1:0] WR_DAT_VLD, WR_DAT_RDY, RD_DAT_VLD, RD_DAT_LST, RD_DAT_RDY;
   logic [NB*DW-1:0] WR_DAT_DAT, RD_DAT_DAT;

   logic [DW-1:0] mem_m [NB][4096];
   int n_err = 0;
   int n_chk = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   eeg_aram_agen dut (
      .clk(clk), .rst_n(rst_n), .IS_IDLE(IS_IDLE), .DONE(DONE),
      .CFG_INFO_VLD(CFG_INFO_VLD), .CFG_INFO_RDY(CFG_INFO_RDY), .CFG_INFO_CMD(CFG_INFO_CMD),
      .CFG_BANK_MSK(CFG_BANK_MSK), .CFG_BASE_ADD(CFG_BASE_ADD), .CFG_STRIDE(CFG_STRIDE),
      .CFG_LENGTH(CFG_LENGTH), .WR_DAT_VLD(WR_DAT_VLD), .WR_DAT_RDY(WR_DAT_RDY),
      .WR_DAT_DAT(WR_DAT_DAT), .RD_DAT_VLD(RD_DAT_VLD), .RD_DAT_LST(RD_DAT_LST),
      .RD_DAT_RDY(RD_DAT_RDY), .RD_DAT_DAT(RD_DAT_DAT)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int addr_of(input int base, input int stride, input int k);
      return (base + k * stride) % 4096;
   endfunction

   // Presents one command at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [1:0] cmd, input logic [NB-1:0] msk, input int base,
                        input int stride, input int len, output int acc);
      int t = 0;
      @(negedge clk);
      while (!CFG_INFO_RDY && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("cfg_rdy_wait", 32'(t < 100), 32'd1);
      CFG_INFO_VLD = 1'b1;
      CFG_INFO_CMD = cmd;
      CFG_BANK_MSK = msk;
      CFG_BASE_ADD = AW'(base);
      CFG_STRIDE   = AW'(stride);
      CFG_LENGTH   = LW'(len);
      @(negedge clk);
      acc = cyc;
      CFG_INFO_VLD = 1'b0;
   endtask

   task automatic finish_cmd(input int dlat);
      chk("done_seen", 32'(dlat >= 0), 32'd1);
      @(negedge clk);
      chk("done_single", 32'(DONE), 32'd0);
      chk("idle_after_done", 32'(IS_IDLE), 32'd1);
   endtask

   task automatic wait_done(input int acc, output int dlat);
      dlat = -1;
      for (int t = 0; t < 200; t++) begin
         if (DONE) begin
            dlat = cyc - acc;
            chk("done_cfg_rdy", 32'(CFG_INFO_RDY), 32'd0);
            break;
         end
         @(negedge clk);
      end
      finish_cmd(dlat);
   endtask

   task automatic do_write(input logic [NB-1:0] msk, input int base, input int stride,
                           input int len, input bit rnd, output int dlat);
      int acc;
      int idx [NB];
      bit bad_rdy = 1'b0;
      logic [DW-1:0] d;
      bit v;
      dlat = -1;
      for (int b = 0; b < NB; b++) idx[b] = 0;
      issue(2'd1, msk, base, stride, len, acc);
      for (int t = 0; t < 3000; t++) begin
         if (DONE) begin
            dlat = cyc - acc;
            chk("wr_done_cfg_rdy", 32'(CFG_INFO_RDY), 32'd0);
            break;
         end
         for (int b = 0; b < NB; b++) begin
            if (!msk[b]) begin
               WR_DAT_VLD[b] = 1'b1;
               WR_DAT_DAT[b*DW +: DW] = DW'($urandom);
               if (WR_DAT_RDY[b]) bad_rdy = 1'b1;
            end else if (idx[b] <= len) begin
               v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
               d = rnd ? DW'($urandom) : DW'(b * 16 + idx[b]);
               WR_DAT_VLD[b] = v;
               WR_DAT_DAT[b*DW +: DW] = d;
               if (v && WR_DAT_RDY[b]) begin
                  mem_m[b][addr_of(base, stride, idx[b])] = d;
                  idx[b]++;
               end
            end else begin
               WR_DAT_VLD[b] = 1'b0;
            end
         end
         @(negedge clk);
      end
      WR_DAT_VLD = '0;
      for (int b = 0; b < NB; b++)
         if (msk[b]) chk($sformatf("wr_count_b%0d", b), 32'(idx[b]), 32'(len + 1));
      chk("wr_unmasked_rdy", 32'(bad_rdy), 32'd0);
      finish_cmd(dlat);
   endtask

   task automatic do_read(input logic [NB-1:0] msk, input int base, input int stride,
                          input int len, input bit rnd, output int first, output int dlat);
      int acc;
      int k [NB];
      bit hold [NB];
      logic [DW-1:0] hdat [NB];
      logic hlst [NB];
      bit bad_unm = 1'b0;
      int bad_hold = 0;
      bit r;
      first = -1;
      dlat  = -1;
      for (int b = 0; b < NB; b++) begin
         k[b] = 0;
         hold[b] = 1'b0;
      end
      issue(2'd2, msk, base, stride, len, acc);
      for (int t = 0; t < 3000; t++) begin
         if (DONE) begin
            dlat = cyc - acc;
            chk("rd_done_cfg_rdy", 32'(CFG_INFO_RDY), 32'd0);
            break;
         end
         if (first < 0 && (RD_DAT_VLD & msk) != '0) first = cyc - acc;
         for (int b = 0; b < NB; b++) begin
            if (!msk[b]) begin
               if (RD_DAT_VLD[b]) bad_unm = 1'b1;
               RD_DAT_RDY[b] = 1'($urandom_range(0, 1));
            end else begin
               if (hold[b] && (!RD_DAT_VLD[b] || RD_DAT_DAT[b*DW +: DW] !== hdat[b] ||
                               RD_DAT_LST[b] !== hlst[b]))
                  bad_hold++;
               r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
               RD_DAT_RDY[b] = r;
               if (RD_DAT_VLD[b] && r) begin
                  chk($sformatf("rd_dat_b%0d_k%0d", b, k[b]), 32'(RD_DAT_DAT[b*DW +: DW]),
                      32'(mem_m[b][addr_of(base, stride, k[b])]));
                  chk($sformatf("rd_lst_b%0d_k%0d", b, k[b]), 32'(RD_DAT_LST[b]),
                      32'(k[b] == len));
                  k[b]++;
                  hold[b] = 1'b0;
               end else if (RD_DAT_VLD[b]) begin
                  hold[b] = 1'b1;
                  hdat[b] = RD_DAT_DAT[b*DW +: DW];
                  hlst[b] = RD_DAT_LST[b];
               end else begin
                  hold[b] = 1'b0;
               end
            end
         end
         @(negedge clk);
      end
      RD_DAT_RDY = '0;
      for (int b = 0; b < NB; b++)
         if (msk[b]) chk($sformatf("rd_count_b%0d", b), 32'(k[b]), 32'(len + 1));
      chk("rd_unmasked_vld", 32'(bad_unm), 32'd0);
      chk("rd_hold_stable", 32'(bad_hold), 32'd0);
      finish_cmd(dlat);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, dlat, first, bad;
      rst_n = 1'b0;
      CFG_INFO_VLD = 1'b0; CFG_INFO_CMD = 2'd0; CFG_BANK_MSK = '0;
      CFG_BASE_ADD = '0; CFG_STRIDE = '0; CFG_LENGTH = '0;
      WR_DAT_VLD = '0; WR_DAT_DAT = '0; RD_DAT_RDY = '0;
      repeat (3) @(negedge clk);
      chk("rst_is_idle", 32'(IS_IDLE), 32'd1);
      chk("rst_cfg_rdy", 32'(CFG_INFO_RDY), 32'd1);
      chk("rst_done", 32'(DONE), 32'd0);
      chk("rst_wr_rdy", 32'(WR_DAT_RDY), 32'd0);
      chk("rst_rd_vld", 32'(RD_DAT_VLD), 32'd0);
      chk("rst_rd_lst", 32'(RD_DAT_LST), 32'd0);
      chk("rst_rd_dat", RD_DAT_DAT, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_rst", 32'(IS_IDLE), 32'd1);

      // Pattern write and full-rate read of the first 16 words of every bank.
      do_write(4'b1111, 0, 1, 15, 1'b0, dlat);
      chk("wr_done_latency", 32'(dlat), 32'd16);
      do_read(4'b1111, 0, 1, 15, 1'b0, first, dlat);
      chk("rd_first_vld_latency", 32'(first), 32'd2);
      chk("rd_done_latency", 32'(dlat), 32'd18);
      do_read(4'b1111, 0, 1, 15, 1'b1, first, dlat);

      // Wrap-around stride and single-address (stride 0) transfers.
      do_write(4'b1111, 12'hFFE, 3, 2, 1'b1, dlat);
      do_read(4'b1111, 12'hFFE, 3, 2, 1'b1, first, dlat);
      do_read(4'b1111, 12'h001, 0, 0, 1'b0, first, dlat);
      chk("rd_len0_latency", 32'(dlat), 32'd3);
      do_read(4'b1111, 12'h004, 0, 1, 1'b0, first, dlat);
      do_write(4'b1010, 12'h100, 0, 3, 1'b1, dlat);
      do_read(4'b1010, 12'h100, 0, 0, 1'b1, first, dlat);

      // Masked clear, then confirm cleared and untouched banks.
      issue(2'd3, 4'b0101, 0, 1, 7, acc);
      for (int k = 0; k < 8; k++) begin
         mem_m[0][k] = '0;
         mem_m[2][k] = '0;
      end
      wait_done(acc, dlat);
      chk("clr_done_latency", 32'(dlat), 32'd8);
      do_read(4'b1111, 0, 1, 15, 1'b1, first, dlat);

      // Degenerate commands.
      issue(2'd0, 4'b1111, 0, 1, 5, acc);
      wait_done(acc, dlat);
      chk("nop_done_latency", 32'(dlat), 32'd0);
      do_read(4'b0000, 0, 1, 15, 1'b0, first, dlat);
      chk("msk0_done_latency", 32'(dlat), 32'd1);

      // Reset in the middle of a stalled read.
      issue(2'd2, 4'b1111, 0, 1, 15, acc);
      repeat (4) @(negedge clk);
      chk("pre_rst_rd_vld", 32'(RD_DAT_VLD), 32'hF);
      rst_n = 1'b0;
      #1;
      chk("midrst_is_idle", 32'(IS_IDLE), 32'd1);
      chk("midrst_rd_vld", 32'(RD_DAT_VLD), 32'd0);
      chk("midrst_done", 32'(DONE), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (DONE || RD_DAT_VLD != '0 || !IS_IDLE) bad++;
      end
      chk("post_rst_quiet", 32'(bad), 32'd0);
      do_read(4'b1111, 0, 1, 3, 1'b1, first, dlat);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
